issue_queue: RTL
================

Name: issue_queue

Overview:
- Circular instruction queue between the ICache fetch stage and the dual-issue decode stage.
- Accepts up to two fetched instructions per cycle and presents the two oldest entries to decode.
- Grants issue according to occupancy and the decode stage's single/dual decision, then retires 1 or 2 entries when decode reports an issue.
- Flushes on branch redirect or exception.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- PTR_W, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high (`RstEnable).
- flush_i  in  1  discard all entries (redirect/exception).
- push_valid1_i  in  1  fetch slot 1 valid.
- push_valid2_i  in  1  fetch slot 2 valid; meaningful only when push_valid1_i=1.
- push_inst1_i  in  32  instruction word, slot 1 (older).
- push_inst2_i  in  32  instruction word, slot 2.
- push_addr1_i  in  32  PC of slot 1.
- push_addr2_i  in  32  PC of slot 2.
- full_o  out  1  fewer than 2 free entries; fetch must hold.
- issue_mode_i  in  1  decode decision: `DualIssue=1, `SingleIssue=0.
- issued_i  in  1  decode consumed the presented instruction(s) this cycle.
- issue_en_o  out  1  enough valid entries for the requested issue mode.
- inst1_o  out  32  oldest entry.
- inst2_o  out  32  second-oldest entry.
- inst1_addr_o  out  32  PC of the oldest entry.
- inst2_addr_o  out  32  PC of the second-oldest entry.
- count_o  out  PTR_W+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky error: a push arrived while full_o=1.

Behaviour:
- Reset (asynchronous, immediate):
  - head=0, tail=0, count=0, overflow_o=0.
  - Storage array is not reset.
  - All data outputs read 0 because count=0.
- Registered state is head, tail, count, overflow flag and storage.
- full_o = (count > DEPTH-2). Combinational from count.
- Push count npush:
  - 0 if full_o=1 or push_valid1_i=0.
  - Otherwise 1 + push_valid2_i.
  - Slot 1 is written at tail, slot 2 at tail+1, modulo DEPTH.
  - tail advances by npush.
  - push_valid2_i without push_valid1_i is ignored (npush=0).
- Overflow: push_valid1_i=1 while full_o=1 sets overflow_o. It stays set until rst or flush_i; the pushed data is dropped.
- issue_en_o = (count>=2) | (count==1 & issue_mode_i==`SingleIssue).
  - Combinational path from issue_mode_i to issue_en_o. Decode must not close a loop through it.
- Pop count npop:
  - 0 unless issued_i & issue_en_o.
  - Then 2 if issue_mode_i==`DualIssue, else 1.
  - head advances by npop.
  - issued_i while issue_en_o=0 is ignored.
- Next occupancy: count_next = count + npush - npop, in a single cycle. Simultaneous push and pop is legal in every combination, including full-minus-pop and empty-plus-push.
- Read outputs (combinational, zero latency from head):
  - inst1_o/inst1_addr_o = mem[head] if count>=1, else 0.
  - inst2_o/inst2_addr_o = mem[head+1 mod DEPTH] if count>=2, else 0.
- Wrap-around: all pointer arithmetic is modulo DEPTH; no bubble is inserted at the wrap.
- flush_i has highest priority:
  - Next cycle: head=tail=0, count=0, overflow_o=0.
  - Pushes and pops in the same cycle are discarded.
- Write-then-read: an entry pushed in cycle N is visible on the outputs in cycle N+1, never in cycle N. There is no bypass.
- Latency summary: push to presentable = 1 cycle; pop to next pair presented = 1 cycle.

Decomposition:
- Shared defines.v supplies `InstBus, `InstAddrBus, `DualIssue, `SingleIssue, `RstEnable, `ZeroWord.
- Add `IQDepth and `IQPtrBus to defines.v.
- One natural sub-module: issue_queue_ram, a DEPTH x 64-bit {addr,inst} array with 2 write ports and 2 asynchronous read ports. It has no reset.
- Pointer, count and flag logic stay in issue_queue.

Test Plan:
1. Reset; push pair (0xBFC00000: 0x24010001, 0xBFC00004: 0x24020002) -> next cycle count_o=2, inst1_addr_o=0xBFC00000, inst2_o=0x24020002, issue_en_o=1, full_o=0.
2. count=2, dual issue with issued_i=1 and a simultaneous push of 0xBFC00008/0C -> count_o stays 2; outputs advance to 0xBFC00008/0xBFC0000C.
3. Fill to 15 entries -> full_o=1; push pair -> count_o remains 15, overflow_o=1; a dual pop then clears full_o (count 13).
4. Wrap: head=15, count=2 -> inst1 from slot 15, inst2 from slot 0; a dual pop leaves head=1, count=0, outputs 0.
5. count=1: issue_mode_i=Single -> issue_en_o=1, a pop gives count 0. With issue_mode_i=Dual -> issue_en_o=0, and issued_i=1 does not change count.
6. Flush with simultaneous push and pop at count=9 -> next cycle count_o=0, issue_en_o=0, overflow_o=0. Asserting rst mid-burst clears count_o in the same cycle, before the clock edge.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared constants and types for the fetch-to-decode issue queue.
// Supplies the queue geometry, the decode issue-mode encodings, the zero
// word used on empty read slots, and the packed {addr, inst} entry layout
// held in the storage array.
package issue_queue_pkg;

    localparam int IQ_DEPTH = 16;
    localparam int IQ_PTR_W = 4;

    localparam logic DUAL_ISSUE   = 1'b1;
    localparam logic SINGLE_ISSUE = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_if.sv
// Fetch/decode-side bundle of the issue queue.
// Ports (seen from the queue, modport slave):
//   flush_i                       discard all entries
//   push_valid1_i / push_valid2_i fetch slot valids (slot 2 needs slot 1)
//   push_inst1_i / push_inst2_i   instruction words, slot 1 is older
//   push_addr1_i / push_addr2_i   PCs of the fetch slots
//   full_o                        fewer than two free entries
//   issue_mode_i                  decode decision, dual=1 single=0
//   issued_i                      decode consumed the presented entries
//   issue_en_o                    enough entries for the requested mode
//   inst1_o / inst1_addr_o        oldest entry
//   inst2_o / inst2_addr_o        second-oldest entry
//   count_o                       occupancy, 0..DEPTH
//   overflow_o                    sticky push-while-full error
// The master modport is the mirror image, used by whoever drives the queue.
interface issue_queue_if
    import issue_queue_pkg::*;
    #(parameter int PTR_W = IQ_PTR_W)
    ();

    logic             flush_i;
    logic             push_valid1_i;
    logic             push_valid2_i;
    logic [31:0]      push_inst1_i;
    logic [31:0]      push_inst2_i;
    logic [31:0]      push_addr1_i;
    logic [31:0]      push_addr2_i;
    logic             full_o;
    logic             issue_mode_i;
    logic             issued_i;
    logic             issue_en_o;
    logic [31:0]      inst1_o;
    logic [31:0]      inst2_o;
    logic [31:0]      inst1_addr_o;
    logic [31:0]      inst2_addr_o;
    logic [PTR_W:0]   count_o;
    logic             overflow_o;

    modport slave (
        input  flush_i, push_valid1_i, push_valid2_i,
        input  push_inst1_i, push_inst2_i, push_addr1_i, push_addr2_i,
        input  issue_mode_i, issued_i,
        output full_o, issue_en_o,
        output inst1_o, inst2_o, inst1_addr_o, inst2_addr_o,
        output count_o, overflow_o
    );

    modport master (
        output flush_i, push_valid1_i, push_valid2_i,
        output push_inst1_i, push_inst2_i, push_addr1_i, push_addr2_i,
        output issue_mode_i, issued_i,
        input  full_o, issue_en_o,
        input  inst1_o, inst2_o, inst1_addr_o, inst2_addr_o,
        input  count_o, overflow_o
    );

endinterface

// File: rtl/issue_queue_ram.sv
// DEPTH x 64-bit {addr, inst} storage for the issue queue.
// Ports:
//   clk              write clock
//   we1/waddr1/wdata1 write port 1 (fetch slot 1)
//   we2/waddr2/wdata2 write port 2 (fetch slot 2)
//   raddr1/rdata1    asynchronous read port 1 (oldest entry)
//   raddr2/rdata2    asynchronous read port 2 (second-oldest entry)
// No reset: validity of each slot is tracked by the queue's occupancy.
module issue_queue_ram
    import issue_queue_pkg::*;
    #(
        parameter int DEPTH = IQ_DEPTH,
        parameter int PTR_W = IQ_PTR_W
    )
    (
        input  logic             clk,
        input  logic             we1,
        input  logic [PTR_W-1:0] waddr1,
        input  iq_entry_t        wdata1,
        input  logic             we2,
        input  logic [PTR_W-1:0] waddr2,
        input  iq_entry_t        wdata2,
        input  logic [PTR_W-1:0] raddr1,
        output iq_entry_t        rdata1,
        input  logic [PTR_W-1:0] raddr2,
        output iq_entry_t        rdata2
    );

    iq_entry_t mem [DEPTH];

    // The two write addresses are always consecutive slots, so they never collide.
    always_ff @(posedge clk) begin
        if (we1) mem[waddr1] <= wdata1;
        if (we2) mem[waddr2] <= wdata2;
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/issue_queue.sv
// Circular instruction queue between ICache fetch and dual-issue decode.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   iq   fetch/decode bundle (issue_queue_if.slave), see the interface file
// Accepts up to two instructions per cycle, presents the two oldest, and
// retires one or two when decode issues. Flush clears everything.
module issue_queue
    import issue_queue_pkg::*;
    #(
        parameter int DEPTH = IQ_DEPTH,
        parameter int PTR_W = IQ_PTR_W
    )
    (
        input  logic          clk,
        input  logic          rst,
        issue_queue_if.slave  iq
    );

    localparam logic [PTR_W:0] FULL_LIMIT = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_TWO    = (PTR_W+1)'(2);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             overflow;

    logic             full;
    logic             issue_en;
    logic [1:0]       npush;
    logic [1:0]       npop;
    iq_entry_t        rd1;
    iq_entry_t        rd2;

    // Pushes are refused outright when full, so the sticky flag is the only trace of them.
    always_comb begin
        full     = (count > FULL_LIMIT);
        issue_en = (count >= CNT_TWO) ||
                   ((count == CNT_ONE) && (iq.issue_mode_i == SINGLE_ISSUE));

        npush = 2'd0;
        if (!full && iq.push_valid1_i)
            npush = iq.push_valid2_i ? 2'd2 : 2'd1;

        npop = 2'd0;
        if (iq.issued_i && issue_en)
            npop = (iq.issue_mode_i == DUAL_ISSUE) ? 2'd2 : 2'd1;
    end

    issue_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk    (clk),
        .we1    ((npush != 2'd0) && !iq.flush_i),
        .waddr1 (tail),
        .wdata1 ('{addr: iq.push_addr1_i, inst: iq.push_inst1_i}),
        .we2    ((npush == 2'd2) && !iq.flush_i),
        .waddr2 (tail + PTR_W'(1)),
        .wdata2 ('{addr: iq.push_addr2_i, inst: iq.push_inst2_i}),
        .raddr1 (head),
        .rdata1 (rd1),
        .raddr2 (head + PTR_W'(1)),
        .rdata2 (rd2)
    );

    // Flush outranks any same-cycle push or pop; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (iq.flush_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            head  <= head + PTR_W'(npop);
            tail  <= tail + PTR_W'(npush);
            count <= count + (PTR_W+1)'(npush) - (PTR_W+1)'(npop);
            if (iq.push_valid1_i && full)
                overflow <= 1'b1;
        end
    end

    // Slots beyond the current occupancy hold stale data and are masked to zero.
    always_comb begin
        iq.inst1_o      = (count >= CNT_ONE) ? rd1.inst : ZERO_WORD;
        iq.inst1_addr_o = (count >= CNT_ONE) ? rd1.addr : ZERO_WORD;
        iq.inst2_o      = (count >= CNT_TWO) ? rd2.inst : ZERO_WORD;
        iq.inst2_addr_o = (count >= CNT_TWO) ? rd2.addr : ZERO_WORD;
    end

    assign iq.full_o     = full;
    assign iq.issue_en_o = issue_en;
    assign iq.count_o    = count;
    assign iq.overflow_o = overflow;

endmodule
